// File: rtl/sbqm_param_core_if.sv
// Board-side signal bundle for the SBqM queue-management core.
// The master side drives raw sensors and teller levels. The slave side is the core.
interface sbqm_param_core_if #(
   parameter int N_TELLERS = 3,
   parameter int CNT_W     = 3,
   parameter int WT_W      = 5
);
   logic                 sensor_in;
   logic                 sensor_out;
   logic [N_TELLERS-1:0] teller_active;
   logic [CNT_W-1:0]     pcount;
   logic                 empty;
   logic                 full;
   logic                 entry_rejected;
   logic                 exit_rejected;
   logic [WT_W-1:0]      wtime;
   logic                 wtime_valid;
   logic                 busy;

   modport master (
      output sensor_in, sensor_out, teller_active,
      input  pcount, empty, full, entry_rejected, exit_rejected,
             wtime, wtime_valid, busy
   );

   modport slave (
      input  sensor_in, sensor_out, teller_active,
      output pcount, empty, full, entry_rejected, exit_rejected,
             wtime, wtime_valid, busy
   );
endinterface

// File: rtl/sbqm_param_core.sv
// SBqM queue-management core.
// It debounces the entry and exit sensors and keeps a saturating customer count.
// It derives the expected waiting time with a serial restoring divider.
module sbqm_param_core #(
   parameter int DEPTH      = 7,
   parameter int N_TELLERS  = 3,
   parameter int SVC_TIME   = 3,
   parameter int DEB_CYCLES = 4,
   parameter int WT_W       = 5
) (
   input  logic               clk,
   input  logic               rst,
   sbqm_param_core_if.slave   bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int TW    = $clog2(N_TELLERS + 1);
   localparam int NUM_W = $clog2(SVC_TIME * (DEPTH + N_TELLERS - 1) + 1);
   localparam int IW    = $clog2(NUM_W + 1);
   localparam int DW    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   typedef enum logic {S_IDLE, S_DIV} state_t;

   // ---------------- sensor path (bit 0 = entry, bit 1 = exit) ----------------
   logic [1:0]    w_raw;
   logic [1:0]    r_s1, r_s2, r_deb, r_deb_d;
   logic [DW-1:0] r_dcnt [2];
   logic [1:0]    w_evt;
   logic          w_inc, w_dec;

   assign w_raw = {bus.sensor_out, bus.sensor_in};

   // Synchronise both sensors, then flip each debounced level after DEB_CYCLES disagreeing cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1    <= '0;
         r_s2    <= '0;
         r_deb   <= '0;
         r_deb_d <= '0;
         for (int unsigned i = 0; i < 2; i++) r_dcnt[i] <= '0;
      end else begin
         r_s1    <= w_raw;
         r_s2    <= r_s1;
         r_deb_d <= r_deb;
         for (int unsigned i = 0; i < 2; i++) begin
            if (r_s2[i] == r_deb[i]) begin
               r_dcnt[i] <= '0;
            end else if (r_dcnt[i] == DW'(DEB_CYCLES - 1)) begin
               r_deb[i]  <= r_s2[i];
               r_dcnt[i] <= '0;
            end else begin
               r_dcnt[i] <= r_dcnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_evt = r_deb & ~r_deb_d;
   assign w_inc = w_evt[0];
   assign w_dec = w_evt[1];

   // ---------------- teller path ----------------
   logic [N_TELLERS-1:0] r_ts1, r_ts2;
   logic [TW-1:0]        r_tcount, w_pop;

   // Count the active tellers in the synchronised vector.
   always_comb begin
      w_pop = '0;
      for (int unsigned i = 0; i < N_TELLERS; i++) w_pop = w_pop + TW'(r_ts2[i]);
   end

   // Synchronise teller levels and register their popcount.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ts1    <= '0;
         r_ts2    <= '0;
         r_tcount <= '0;
      end else begin
         r_ts1    <= bus.teller_active;
         r_ts2    <= r_ts1;
         r_tcount <= w_pop;
      end
   end

   // ---------------- customer counter ----------------
   logic [CNT_W-1:0] r_pcount, w_pcount_nx;
   logic             r_ent_rej, r_exi_rej, w_ent_rej_nx, w_exi_rej_nx;
   logic             w_empty, w_full;

   assign w_empty = (r_pcount == '0);
   assign w_full  = (r_pcount == CNT_W'(DEPTH));

   // Apply entry/exit events with saturation. A simultaneous pair at a bound moves away from it.
   always_comb begin
      w_pcount_nx  = r_pcount;
      w_ent_rej_nx = 1'b0;
      w_exi_rej_nx = 1'b0;
      unique case ({w_inc, w_dec})
         2'b10: if (w_full) w_ent_rej_nx = 1'b1; else w_pcount_nx = r_pcount + 1'b1;
         2'b01: if (w_empty) w_exi_rej_nx = 1'b1; else w_pcount_nx = r_pcount - 1'b1;
         2'b11: begin
            if (w_empty)     w_pcount_nx = r_pcount + 1'b1;
            else if (w_full) w_pcount_nx = r_pcount - 1'b1;
         end
         default: ;
      endcase
   end

   // Customer count and reject pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pcount  <= '0;
         r_ent_rej <= 1'b0;
         r_exi_rej <= 1'b0;
      end else begin
         r_pcount  <= w_pcount_nx;
         r_ent_rej <= w_ent_rej_nx;
         r_exi_rej <= w_exi_rej_nx;
      end
   end

   // ---------------- waiting-time divider ----------------
   state_t           r_state, w_state_nx;
   logic [CNT_W-1:0] r_op_p, w_op_p_nx;
   logic [TW-1:0]    r_op_t, w_op_t_nx;
   logic [NUM_W-1:0] r_num, w_num_nx, w_numer, w_shift;
   logic [TW-1:0]    r_rem, w_rem_nx;
   logic [IW-1:0]    r_iter, w_iter_nx;
   logic [WT_W-1:0]  r_wtime, w_wtime_nx;
   logic             r_valid, w_valid_nx;
   logic [TW:0]      w_trial;
   logic             w_qbit, w_chg;

   // ceil(SVC_TIME*p/t) realised as floor((SVC_TIME*p + t - 1)/t). An empty queue forces zero.
   assign w_numer = (r_pcount == '0) ? '0 :
                    NUM_W'(SVC_TIME * int'(r_pcount) + int'(r_tcount) - 1);
   assign w_chg   = (r_pcount != r_op_p) || (r_tcount != r_op_t);
   assign w_trial = {r_rem, r_num[NUM_W-1]};
   assign w_qbit  = (w_trial >= {1'b0, r_op_t});
   assign w_shift = NUM_W'({r_num, w_qbit});

   // Next-state logic. An operand change takes priority, so it also aborts a division that is in progress.
   always_comb begin
      w_state_nx = r_state;
      w_op_p_nx  = r_op_p;
      w_op_t_nx  = r_op_t;
      w_num_nx   = r_num;
      w_rem_nx   = r_rem;
      w_iter_nx  = r_iter;
      w_wtime_nx = r_wtime;
      w_valid_nx = r_valid;
      if (w_chg) begin
         w_op_p_nx  = r_pcount;
         w_op_t_nx  = r_tcount;
         w_num_nx   = w_numer;
         w_rem_nx   = '0;
         w_iter_nx  = '0;
         w_valid_nx = 1'b0;
         if (r_tcount == '0) begin
            w_state_nx = S_IDLE;
            w_wtime_nx = '0;
         end else begin
            w_state_nx = S_DIV;
         end
      end else if (r_state == S_DIV) begin
         w_num_nx = w_shift;
         w_rem_nx = w_qbit ? TW'(w_trial - {1'b0, r_op_t}) : w_trial[TW-1:0];
         if (r_iter == IW'(NUM_W - 1)) begin
            w_state_nx = S_IDLE;
            w_wtime_nx = WT_W'(w_shift);
            w_valid_nx = 1'b1;
         end else begin
            w_iter_nx = r_iter + 1'b1;
         end
      end
   end

   // Divider state, operand and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_op_p  <= '0;
         r_op_t  <= '0;
         r_num   <= '0;
         r_rem   <= '0;
         r_iter  <= '0;
         r_wtime <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_op_p  <= w_op_p_nx;
         r_op_t  <= w_op_t_nx;
         r_num   <= w_num_nx;
         r_rem   <= w_rem_nx;
         r_iter  <= w_iter_nx;
         r_wtime <= w_wtime_nx;
         r_valid <= w_valid_nx;
      end
   end

   assign bus.pcount         = r_pcount;
   assign bus.empty          = w_empty;
   assign bus.full           = w_full;
   assign bus.entry_rejected = r_ent_rej;
   assign bus.exit_rejected  = r_exi_rej;
   assign bus.wtime          = r_wtime;
   assign bus.wtime_valid    = r_valid;
   assign bus.busy           = (r_state == S_DIV);
endmodule

// File: tb/tb_sbqm_param_core.sv
// Directed bench for sbqm_param_core with default parameters.
// The settling table is followed by cycle-exact sequences for latency, glitch, abort and reset.
module tb_sbqm_param_core;
   localparam int DEPTH = 7;
   localparam int NT    = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   sbqm_param_core_if #(.N_TELLERS(NT), .CNT_W(3), .WT_W(5)) bus ();

   sbqm_param_core #(
      .DEPTH(DEPTH), .N_TELLERS(NT), .SVC_TIME(3), .DEB_CYCLES(4), .WT_W(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef enum int {K_ENT, K_EXI, K_BOTH, K_TELL} kind_t;
   typedef struct {
      kind_t      kind;
      logic [2:0] tell;
      int         p;
      int         wt;
      int         erej;
      int         xrej;
   } vec_t;

   vec_t vq[$];

   task automatic add(input kind_t k, input logic [2:0] t, input int p, input int wt,
                      input int er, input int xr);
      vec_t v;
      v.kind = k; v.tell = t; v.p = p; v.wt = wt; v.erej = er; v.xrej = xr;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive a 10-cycle sensor pulse, release it, and count reject pulses along the way.
   task automatic pulse(input logic a, input logic b, output int ne, output int nx);
      ne = 0; nx = 0;
      @(negedge clk);
      bus.sensor_in = a; bus.sensor_out = b;
      repeat (10) begin
         @(negedge clk);
         ne += int'(bus.entry_rejected);
         nx += int'(bus.exit_rejected);
      end
      bus.sensor_in = 1'b0; bus.sensor_out = 1'b0;
      repeat (10) begin
         @(negedge clk);
         ne += int'(bus.entry_rejected);
         nx += int'(bus.exit_rejected);
      end
   endtask

   task automatic wait_valid(input string name);
      int k = 0;
      while (!(bus.wtime_valid && !bus.busy) && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk({name, " valid"}, int'(bus.wtime_valid), 1);
   endtask

   initial begin
      int ne, nx;
      string nm;
      bus.sensor_in = 1'b0; bus.sensor_out = 1'b0; bus.teller_active = '0;

      // Table of settled results after each action: kind, tellers, pcount, wtime, entry rejects, exit rejects.
      for (int i = 1; i <= 5; i++) add(K_ENT, 3'b111, i, i, 0, 0);
      add(K_TELL, 3'b001, 5, 15, 0, 0);
      add(K_TELL, 3'b011, 5, 8, 0, 0);
      add(K_ENT,  3'b011, 6, 9, 0, 0);
      add(K_TELL, 3'b001, 6, 18, 0, 0);
      add(K_ENT,  3'b001, 7, 21, 0, 0);
      add(K_ENT,  3'b001, 7, 21, 1, 0);
      add(K_TELL, 3'b111, 7, 7, 0, 0);
      add(K_EXI,  3'b111, 6, 6, 0, 0);
      add(K_BOTH, 3'b111, 6, 6, 0, 0);
      for (int i = 5; i >= 0; i--) add(K_EXI, 3'b111, i, i, 0, 0);
      add(K_EXI,  3'b111, 0, 0, 0, 1);
      add(K_BOTH, 3'b111, 1, 1, 0, 0);
      add(K_ENT,  3'b111, 2, 2, 0, 0);
      add(K_ENT,  3'b111, 3, 3, 0, 0);
      add(K_BOTH, 3'b111, 3, 3, 0, 0);
      for (int i = 4; i <= 7; i++) add(K_ENT, 3'b111, i, i, 0, 0);
      add(K_BOTH, 3'b111, 6, 6, 0, 0);

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst pcount", int'(bus.pcount), 0);
      chk("rst empty", int'(bus.empty), 1);
      chk("rst full", int'(bus.full), 0);
      chk("rst erej", int'(bus.entry_rejected), 0);
      chk("rst xrej", int'(bus.exit_rejected), 0);
      chk("rst wtime", int'(bus.wtime), 0);
      chk("rst valid", int'(bus.wtime_valid), 0);
      chk("rst busy", int'(bus.busy), 0);
      rst = 1'b0;

      // Teller latency 3 edges, then divider latency 6 edges: valid rises on edge 9.
      @(negedge clk);
      bus.teller_active = 3'b111;
      repeat (8) @(negedge clk);
      chk("lat valid@8", int'(bus.wtime_valid), 0);
      chk("lat busy@8", int'(bus.busy), 1);
      @(negedge clk);
      chk("lat valid@9", int'(bus.wtime_valid), 1);
      chk("lat busy@9", int'(bus.busy), 0);
      chk("lat wtime@9", int'(bus.wtime), 0);

      foreach (vq[i]) begin
         case (vq[i].kind)
            K_ENT:  pulse(1'b1, 1'b0, ne, nx);
            K_EXI:  pulse(1'b0, 1'b1, ne, nx);
            K_BOTH: pulse(1'b1, 1'b1, ne, nx);
            default: begin
               @(negedge clk);
               bus.teller_active = vq[i].tell;
               repeat (6) @(negedge clk);
               ne = 0; nx = 0;
            end
         endcase
         nm = $sformatf("v%0d", i);
         wait_valid(nm);
         chk({nm, " pcount"}, int'(bus.pcount), vq[i].p);
         chk({nm, " empty"}, int'(bus.empty), int'(vq[i].p == 0));
         chk({nm, " full"}, int'(bus.full), int'(vq[i].p == DEPTH));
         chk({nm, " wtime"}, int'(bus.wtime), vq[i].wt);
         chk({nm, " erej"}, ne, vq[i].erej);
         chk({nm, " xrej"}, nx, vq[i].xrej);
      end

      // A 2-cycle glitch must not count.
      @(negedge clk);
      bus.sensor_in = 1'b1;
      repeat (2) @(negedge clk);
      bus.sensor_in = 1'b0;
      repeat (15) @(negedge clk);
      chk("glitch pcount", int'(bus.pcount), 6);

      // A held pulse updates pcount exactly on edge 7.
      bus.sensor_in = 1'b1;
      repeat (6) @(negedge clk);
      chk("edge6 pcount", int'(bus.pcount), 6);
      @(negedge clk);
      chk("edge7 pcount", int'(bus.pcount), 7);
      repeat (3) @(negedge clk);
      bus.sensor_in = 1'b0;
      repeat (10) @(negedge clk);
      wait_valid("p7");
      chk("p7 wtime", int'(bus.wtime), 7);
      chk("p7 full", int'(bus.full), 1);

      for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, ne, nx);
      wait_valid("p4");
      chk("p4 pcount", int'(bus.pcount), 4);
      chk("p4 wtime", int'(bus.wtime), 4);

      // With no tellers, the waiting time is 0 and not valid.
      @(negedge clk);
      bus.teller_active = 3'b000;
      repeat (6) @(negedge clk);
      chk("t0 wtime", int'(bus.wtime), 0);
      chk("t0 valid", int'(bus.wtime_valid), 0);
      chk("t0 busy", int'(bus.busy), 0);

      // A teller change mid-division restarts it, and valid rises 6 edges after the new tcount.
      @(negedge clk);
      bus.teller_active = 3'b111;
      repeat (5) @(negedge clk);
      chk("abort busy@5", int'(bus.busy), 1);
      bus.teller_active = 3'b011;
      for (int e = 6; e <= 13; e++) begin
         @(negedge clk);
         chk($sformatf("abort valid@%0d", e), int'(bus.wtime_valid), 0);
         chk($sformatf("abort busy@%0d", e), int'(bus.busy), 1);
      end
      @(negedge clk);
      chk("abort valid@14", int'(bus.wtime_valid), 1);
      chk("abort busy@14", int'(bus.busy), 0);
      chk("abort wtime@14", int'(bus.wtime), 6);

      // Reset during a division clears everything immediately.
      bus.teller_active = 3'b001;
      repeat (5) @(negedge clk);
      chk("mid busy", int'(bus.busy), 1);
      chk("mid wtime", int'(bus.wtime), 6);
      #2 rst = 1'b1;
      #1;
      chk("arst busy", int'(bus.busy), 0);
      chk("arst wtime", int'(bus.wtime), 0);
      chk("arst valid", int'(bus.wtime_valid), 0);
      chk("arst pcount", int'(bus.pcount), 0);
      chk("arst empty", int'(bus.empty), 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      wait_valid("post rst");
      chk("post rst wtime", int'(bus.wtime), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
